// File: rtl/pcs_10g_slip_ctrl_if.sv
// Signal bundle between block sync / gearbox and the slip controller.
// The master side drives the sync status; the slave side is the controller.
interface pcs_10g_slip_ctrl_if;
  logic       enable;
  logic       rx_valid;
  logic       slip_req;
  logic       block_lock;
  logic       hi_ber;
  logic       gb_slip;
  logic       sync_hold;
  logic       rx_restart;
  logic       align_fail;
  logic       link_up;
  logic [6:0] slip_count;
  logic [7:0] fail_count;

  modport master (
    output enable, rx_valid, slip_req, block_lock, hi_ber,
    input  gb_slip, sync_hold, rx_restart, align_fail, link_up, slip_count, fail_count
  );

  modport slave (
    input  enable, rx_valid, slip_req, block_lock, hi_ber,
    output gb_slip, sync_hold, rx_restart, align_fail, link_up, slip_count, fail_count
  );
endinterface

// File: rtl/pcs_10g_slip_ctrl.sv
// Alignment sequencer: rate-limits gearbox slips, bounds the search to one
// rotation with an RX restart on failure, and qualifies link_up after lock.
module pcs_10g_slip_ctrl #(
  parameter int SLIP_HOLDOFF  = 4,
  parameter int MAX_SLIPS     = 66,
  parameter int LINK_UP_DELAY = 16,
  parameter int RESTART_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pcs_10g_slip_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, SEARCH, HOLDOFF, LOCKED, RESTART} state_t;

  localparam logic [3:0] HOLD_LOAD    = 4'(SLIP_HOLDOFF);
  localparam logic [6:0] SLIP_LAST    = 7'(MAX_SLIPS - 1);
  localparam logic [7:0] GOOD_TARGET  = 8'(LINK_UP_DELAY);
  localparam logic [7:0] RESTART_LOAD = 8'(RESTART_LEN);

  state_t     state, state_n;
  logic [3:0] hold_cnt, hold_n;
  logic [7:0] good_cnt, good_n;
  logic [7:0] restart_cnt, restart_n;
  logic [6:0] slip_q, slip_n;
  logic [7:0] fail_q, fail_n;
  logic       gb_slip_q, gb_slip_n;
  logic       sync_hold_q, sync_hold_n;
  logic       rx_restart_q, rx_restart_n;
  logic       align_fail_q, align_fail_n;
  logic       link_up_q, link_up_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      good_cnt     <= '0;
      restart_cnt  <= '0;
      slip_q       <= '0;
      fail_q       <= '0;
      gb_slip_q    <= 1'b0;
      sync_hold_q  <= 1'b0;
      rx_restart_q <= 1'b0;
      align_fail_q <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      good_cnt     <= good_n;
      restart_cnt  <= restart_n;
      slip_q       <= slip_n;
      fail_q       <= fail_n;
      gb_slip_q    <= gb_slip_n;
      sync_hold_q  <= sync_hold_n;
      rx_restart_q <= rx_restart_n;
      align_fail_q <= align_fail_n;
      link_up_q    <= link_up_n;
    end
  end

  // Every output is computed here one cycle ahead so it leaves a flop.
  always_comb begin
    state_n      = state;
    hold_n       = hold_cnt;
    good_n       = good_cnt;
    restart_n    = restart_cnt;
    slip_n       = slip_q;
    fail_n       = fail_q;
    gb_slip_n    = 1'b0;
    align_fail_n = 1'b0;
    sync_hold_n  = sync_hold_q;
    rx_restart_n = rx_restart_q;
    link_up_n    = link_up_q;

    if (!bus.enable) begin
      state_n      = IDLE;
      sync_hold_n  = 1'b0;
      rx_restart_n = 1'b0;
      link_up_n    = 1'b0;
      slip_n       = '0;
    end else begin
      case (state)
        IDLE: state_n = SEARCH;

        SEARCH: begin
          if (bus.block_lock) begin
            state_n = LOCKED;
            good_n  = '0;
          end else if (bus.slip_req && slip_q == SLIP_LAST) begin
            state_n      = RESTART;
            align_fail_n = 1'b1;
            rx_restart_n = 1'b1;
            restart_n    = RESTART_LOAD;
            slip_n       = '0;
            if (fail_q != 8'hFF) fail_n = fail_q + 8'd1;
          end else if (bus.slip_req) begin
            state_n     = HOLDOFF;
            gb_slip_n   = 1'b1;
            sync_hold_n = 1'b1;
            slip_n      = slip_q + 7'd1;
            hold_n      = HOLD_LOAD;
          end
        end

        // Only real blocks count toward settling; idle cycles do not.
        HOLDOFF: begin
          sync_hold_n = 1'b1;
          if (bus.rx_valid) begin
            if (hold_cnt == 4'd1) begin
              state_n     = SEARCH;
              sync_hold_n = 1'b0;
            end else begin
              hold_n = hold_cnt - 4'd1;
            end
          end
        end

        LOCKED: begin
          if (!bus.block_lock) begin
            state_n   = SEARCH;
            link_up_n = 1'b0;
            slip_n    = '0;
            good_n    = '0;
          end else if (bus.hi_ber) begin
            good_n    = '0;
            link_up_n = 1'b0;
          end else if (bus.rx_valid && good_cnt != GOOD_TARGET) begin
            good_n = good_cnt + 8'd1;
            if (good_n == GOOD_TARGET) link_up_n = 1'b1;
          end
        end

        RESTART: begin
          if (restart_cnt == 8'd1) begin
            state_n      = SEARCH;
            rx_restart_n = 1'b0;
          end else begin
            restart_n = restart_cnt - 8'd1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.gb_slip    = gb_slip_q;
  assign bus.sync_hold  = sync_hold_q;
  assign bus.rx_restart = rx_restart_q;
  assign bus.align_fail = align_fail_q;
  assign bus.link_up    = link_up_q;
  assign bus.slip_count = slip_q;
  assign bus.fail_count = fail_q;

endmodule

// File: doc/pcs_10g_slip_ctrl.md
# pcs_10g_slip_ctrl

Alignment sequencer between the Clause 49 block-synchronization state machine and the RX gearbox. It turns block-sync slip requests into rate-limited gearbox slip pulses and masks the receiver while the gearbox settles. It bounds the alignment search to one full 66-bit rotation, requesting an RX restart when that fails, and qualifies `link_up` once block lock is stable and BER is normal.

## Interface
Parameters:
- `SLIP_HOLDOFF`, 4: rx_valid blocks masked after each gearbox slip; range 1..15.
- `MAX_SLIPS`, 66: slips allowed per search before declaring alignment failure; range 2..127.
- `LINK_UP_DELAY`, 16: consecutive good locked blocks required before `link_up`; range 1..255.
- `RESTART_LEN`, 8: clock cycles `rx_restart` is held high; range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: PCS RX clock.
- `rst` in 1: asynchronous active-high reset.
- `enable` in 1: level; 0 forces IDLE.
- `rx_valid` in 1: block strobe from gearbox.
- `slip_req` in 1: one-cycle slip request from block sync.
- `block_lock` in 1: block-sync lock status.
- `hi_ber` in 1: block-sync high-BER status.
- `gb_slip` out 1: one-cycle slip pulse to gearbox.
- `sync_hold` out 1: high while the gearbox settles; downstream discards blocks.
- `rx_restart` out 1: RX path restart request.
- `align_fail` out 1: one-cycle pulse when search is exhausted.
- `link_up` out 1: qualified link status.
- `slip_count` out 7: slips issued in current search.
- `fail_count` out 8: saturating count of alignment failures.

## Operation
States: IDLE, SEARCH, HOLDOFF, LOCKED, RESTART. All registered outputs reset to 0; state resets to IDLE.
- `enable` = 0 in any state: go to IDLE next cycle. `gb_slip`, `sync_hold`, `rx_restart`, `link_up` and `slip_count` clear. `fail_count` is retained.
- IDLE: `enable` = 1 → SEARCH.
- SEARCH: checks are evaluated in priority order.
  - `block_lock` = 1 → LOCKED; good-block counter cleared.
  - Else, `slip_req` = 1 and `slip_count` = MAX_SLIPS−1 → RESTART. Pulse `align_fail`, increment `fail_count` (saturating at 255), clear `slip_count`.
  - Else, `slip_req` = 1 → pulse `gb_slip`, increment `slip_count`, load holdoff counter with SLIP_HOLDOFF, go to HOLDOFF.
- HOLDOFF: `sync_hold` = 1. The counter decrements only on `rx_valid`. When `rx_valid` arrives with counter = 1 → SEARCH; `sync_hold` drops the same edge. `slip_req` is ignored (dropped, not queued). `block_lock` is ignored.
- LOCKED:
  - `block_lock` = 0 → SEARCH; `link_up` cleared that edge, `slip_count` cleared, good counter cleared.
  - `hi_ber` = 1 → good counter cleared and `link_up` cleared; state stays LOCKED.
  - Otherwise, each `rx_valid` increments the good counter (saturating at LINK_UP_DELAY). `link_up` sets on the edge where the counter reaches LINK_UP_DELAY.
  - `slip_req` is ignored.
- RESTART: `rx_restart` = 1 for exactly RESTART_LEN cycles, counted on `clk`, independent of `rx_valid`. Then → SEARCH, with `rx_restart` low on entry. All inputs except `enable` are ignored.
- Arithmetic: `slip_count` never exceeds MAX_SLIPS−1. `fail_count` saturates and never wraps.

## Timing
- All outputs are registered.
- `gb_slip` is high for exactly the one cycle after the cycle `slip_req` is sampled in SEARCH. `sync_hold` rises on that same edge.
- The minimum spacing between `gb_slip` pulses is SLIP_HOLDOFF `rx_valid` strobes plus 1 cycle.
- `align_fail`, the `fail_count` increment and the first `rx_restart` cycle all occur on the same edge.
- `link_up` latency: LINK_UP_DELAY `rx_valid` strobes after entering LOCKED, with `hi_ber` low throughout.
- Async `rst` assertion mid-operation: outputs clear immediately, including `fail_count`. Release is synchronous to `clk`.
- `enable` has priority over every other input in every state.

## Test plan
- Nominal slip: enable, then `slip_req` ×3 spaced ≥6 valid blocks apart, then `block_lock` = 1. Required: 3 `gb_slip` pulses, `slip_count` = 3, `sync_hold` high for 4 valid blocks after each slip, `link_up` 16 valid blocks after lock.
- Holdoff drop: issue `slip_req` on every cycle with `rx_valid` every cycle. Required: `gb_slip` exactly every 5th cycle; requests during holdoff are dropped.
- Exhaustion: 66 `slip_req` without lock. Required: 65 `gb_slip` pulses; the 66th request produces `align_fail` pulse, `fail_count` = 1, `rx_restart` high 8 cycles, `slip_count` = 0, then SEARCH.
- BER and lock loss: while `link_up` = 1, pulse `hi_ber`. Required: `link_up` = 0 next edge and re-asserts 16 blocks later. Then drop `block_lock`. Required: `link_up` = 0 and `slip_count` = 0 next edge, state SEARCH.
- Priority and reset: `slip_req` and `block_lock` asserted in the same SEARCH cycle → LOCKED with no `gb_slip`. Deassert `enable` during RESTART → `rx_restart` low next edge, `fail_count` retained. Assert `rst` mid-HOLDOFF → all outputs 0 immediately.
- `fail_count` saturation: force 256 exhaustion cycles. Required: `fail_count` holds 255 and `align_fail` still pulses each time.
